// File: rtl/uni_shift_reg_pkg.sv
// Shared types for the universal shift register: operation encoding and FSM states.
package shift_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'd0,
      SHL  = 3'd1,
      SHR  = 3'd2,
      ROL  = 3'd3,
      ROR  = 3'd4,
      ASR  = 3'd5,
      LOAD = 3'd6,
      CLR  = 3'd7
   } shift_op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   // Ops that move bits and can therefore be repeated as a burst.
   function automatic logic is_shift_op(input shift_op_e op);
      return (op == SHL) || (op == SHR) || (op == ROL) || (op == ROR) || (op == ASR);
   endfunction

endpackage

// File: rtl/uni_shift_reg_shift_unit.sv
// Combinational single-step datapath: next register value and serial-out bit for one op.
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  shift_op_e        op,
   input  logic             din,
   input  logic [WIDTH-1:0] pdata,
   input  logic             sout,
   output logic [WIDTH-1:0] q_next,
   output logic             sout_next
);

   always_comb begin
      q_next    = q;
      sout_next = sout;
      case (op)
         SHL: begin
            q_next    = {q[WIDTH-2:0], din};
            sout_next = q[WIDTH-1];
         end
         SHR: begin
            q_next    = {din, q[WIDTH-1:1]};
            sout_next = q[0];
         end
         ROL: begin
            q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
            sout_next = q[WIDTH-1];
         end
         ROR: begin
            q_next    = {q[0], q[WIDTH-1:1]};
            sout_next = q[0];
         end
         ASR: begin
            q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
            sout_next = q[0];
         end
         LOAD: begin
            q_next    = pdata;
            sout_next = 1'b0;
         end
         CLR: begin
            q_next    = '0;
            sout_next = 1'b0;
         end
         default: begin
            q_next    = q;
            sout_next = sout;
         end
      endcase
   end

endmodule

// File: rtl/uni_shift_reg.sv
// Universal shift register with single-step ops and a counted burst mode (busy/done handshake).
module uni_shift_reg
   import shift_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  shift_op_e        op,
   input  logic             din,
   input  logic [WIDTH-1:0] pdata,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   state_e           state_reg, state_next;
   logic [CNT_W-1:0] rem_reg, rem_next;
   shift_op_e        op_lat_reg, op_lat_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic             sout_reg, sout_next;
   logic             done_reg, done_next;

   shift_op_e        unit_op;
   logic [WIDTH-1:0] unit_q;
   logic             unit_sout;

   // During a burst the latched op drives the datapath; live inputs other than din are ignored.
   assign unit_op = (state_reg == BURST) ? op_lat_reg : op;

   shift_unit #(.WIDTH(WIDTH)) u_shift_unit (
      .q         (q_reg),
      .op        (unit_op),
      .din       (din),
      .pdata     (pdata),
      .sout      (sout_reg),
      .q_next    (unit_q),
      .sout_next (unit_sout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         rem_reg    <= '0;
         op_lat_reg <= HOLD;
         q_reg      <= '0;
         sout_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rem_reg    <= rem_next;
         op_lat_reg <= op_lat_next;
         q_reg      <= q_next;
         sout_reg   <= sout_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      rem_next    = rem_reg;
      op_lat_next = op_lat_reg;
      q_next      = q_reg;
      sout_next   = sout_reg;
      done_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && is_shift_op(op)) begin
               // Accepting edge leaves q untouched; a zero-length burst just reports done.
               if (count != '0) begin
                  state_next  = BURST;
                  rem_next    = count;
                  op_lat_next = op;
               end else begin
                  done_next = 1'b1;
               end
            end else begin
               q_next    = unit_q;
               sout_next = unit_sout;
            end
         end
         BURST: begin
            q_next    = unit_q;
            sout_next = unit_sout;
            rem_next  = rem_reg - CNT_W'(1);
            if (rem_reg == CNT_W'(1)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == BURST);
      q    = q_reg;
      sout = sout_reg;
      done = done_reg;
   end

endmodule

// File: tb/tb_uni_shift_reg.sv
// Directed bench for uni_shift_reg (WIDTH=8): single-step ops, bursts, handshake edges and async reset.
module tb_uni_shift_reg;
   import shift_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             clk = 1'b0;
   logic             reset;
   shift_op_e        op;
   logic             din;
   logic [WIDTH-1:0] pdata;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             busy;
   logic             done;

   int vectors     = 0;
   int miscompares = 0;

   uni_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .op    (op),
      .din   (din),
      .pdata (pdata),
      .start (start),
      .count (count),
      .q     (q),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [7:0] eq, input logic es,
                            input logic eb, input logic ed);
      check({tag, ".q"},    32'(q),    32'(eq));
      check({tag, ".sout"}, 32'(sout), 32'(es));
      check({tag, ".busy"}, 32'(busy), 32'(eb));
      check({tag, ".done"}, 32'(done), 32'(ed));
      $display("step %-12s q=%02h sout=%0b busy=%0b done=%0b", tag, q, sout, busy, done);
   endtask

   initial begin
      reset = 1'b0;
      op    = HOLD;
      din   = 1'b0;
      pdata = '0;
      start = 1'b0;
      count = '0;
      #12;
      chk_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      // Async reset between edges
      op = LOAD; pdata = 8'hFF;
      tick();
      chk_state("load_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
      op = HOLD;
      #2 reset = 1'b0;
      #1 chk_state("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b1;

      // Legacy single-step
      op = SHR; din = 1'b1;
      tick(); chk_state("shr", 8'h80, 1'b0, 1'b0, 1'b0);
      op = HOLD;
      tick(); chk_state("hold", 8'h80, 1'b0, 1'b0, 1'b0);
      op = SHL; din = 1'b1;
      tick(); chk_state("shl", 8'h01, 1'b1, 1'b0, 1'b0);

      // Rotates and arithmetic shift
      op = LOAD; pdata = 8'hB4;
      tick(); chk_state("load_b4", 8'hB4, 1'b0, 1'b0, 1'b0);
      op = ROR;
      tick(); chk_state("ror", 8'h5A, 1'b0, 1'b0, 1'b0);
      op = ROL;
      tick(); chk_state("rol", 8'hB4, 1'b0, 1'b0, 1'b0);
      op = LOAD; pdata = 8'h90;
      tick(); chk_state("load_90", 8'h90, 1'b0, 1'b0, 1'b0);
      op = ASR; din = 1'b0;
      tick(); chk_state("asr", 8'hC8, 1'b0, 1'b0, 1'b0);

      // Burst SHL x3 with input toggling while busy
      op = LOAD; pdata = 8'h81;
      tick(); chk_state("load_81", 8'h81, 1'b0, 1'b0, 1'b0);
      op = SHL; start = 1'b1; count = 4'd3; din = 1'b0;
      tick(); chk_state("b1_accept", 8'h81, 1'b0, 1'b1, 1'b0);
      op = CLR; start = 1'b1; count = 4'd1; pdata = 8'h00;
      tick(); chk_state("b1_sh1", 8'h02, 1'b1, 1'b1, 1'b0);
      op = LOAD; start = 1'b0;
      tick(); chk_state("b1_sh2", 8'h04, 1'b0, 1'b1, 1'b0);
      op = HOLD;
      tick(); chk_state("b1_done", 8'h08, 1'b0, 1'b0, 1'b1);

      // Back-to-back: new start in the done cycle, ROR x2
      op = ROR; start = 1'b1; count = 4'd2;
      tick(); chk_state("b2_accept", 8'h08, 1'b0, 1'b1, 1'b0);
      op = HOLD; start = 1'b0;
      tick(); chk_state("b2_sh1", 8'h04, 1'b0, 1'b1, 1'b0);
      tick(); chk_state("b2_done", 8'h02, 1'b0, 1'b0, 1'b1);
      tick(); chk_state("b2_after", 8'h02, 1'b0, 1'b0, 1'b0);

      // Zero-length burst
      op = SHL; start = 1'b1; count = 4'd0; din = 1'b1;
      tick(); chk_state("z_done", 8'h02, 1'b0, 1'b0, 1'b1);
      op = HOLD; start = 1'b0;
      tick(); chk_state("z_after", 8'h02, 1'b0, 1'b0, 1'b0);

      // Burst longer than WIDTH flushes with din
      op = SHL; start = 1'b1; count = 4'd10; din = 1'b1;
      tick(); chk_state("long_accept", 8'h02, 1'b0, 1'b1, 1'b0);
      op = HOLD; start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         check("long_busy", 32'(busy), 32'd1);
      end
      tick(); chk_state("long_done", 8'hFF, 1'b1, 1'b0, 1'b1);

      // Reset mid-burst aborts without a done pulse
      op = LOAD; pdata = 8'hA5;
      tick(); chk_state("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
      op = SHR; start = 1'b1; count = 4'd7; din = 1'b1;
      tick(); chk_state("r_accept", 8'hA5, 1'b0, 1'b1, 1'b0);
      op = HOLD; start = 1'b0;
      tick(); tick(); tick();
      chk_state("r_sh3", 8'hF4, 1'b1, 1'b1, 1'b0);
      #2 reset = 1'b0;
      #1 chk_state("r_abort", 8'h00, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_state("r_quiet", 8'h00, 1'b0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
